// File: rtl/_3_to_8_hold_decoder_if.sv
// Code/strobe bundle from the 8-to-3 priority encoder plus the decoded line outputs.
// The master drives codes and the slave (decoder) returns the held line state.
interface _3_to_8_hold_decoder_if;
  logic       en_in_n;
  logic [2:0] y;
  logic       gs;
  logic       scan_en;
  logic [7:0] v_n;
  logic       busy;
  logic [2:0] code_q;

  modport master (
    output en_in_n, y, gs, scan_en,
    input  v_n, busy, code_q
  );

  modport slave (
    input  en_in_n, y, gs, scan_en,
    output v_n, busy, code_q
  );
endinterface

// File: rtl/_3_to_8_hold_decoder.sv
// Registered 3-to-8 decoder: a captured code holds its active-low line for HOLD_CYCLES;
// with no code held and scan enabled, a single low line walks across the outputs.
module _3_to_8_hold_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int SCAN_DIV    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  _3_to_8_hold_decoder_if.slave      bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LOAD = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    v_n_q, v_n_d;
  logic          busy_q, busy_d;
  logic [2:0]    code_q_q, code_q_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    scan_idx_q, scan_idx_d;
  logic [2:0]    scan_next;
  logic          cap;

  function automatic logic [7:0] line_n(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

  assign cap       = !bus.en_in_n && !bus.gs;
  assign scan_next = (scan_idx_q == 3'd7) ? 3'd0 : scan_idx_q + 3'd1;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    v_n_d      = v_n_q;
    busy_d     = busy_q;
    code_q_d   = code_q_q;
    hold_cnt_d = hold_cnt_q;
    div_cnt_d  = div_cnt_q;
    scan_idx_d = scan_idx_q;

    // A capture wins from every state and is handled identically, including retrigger.
    if (cap) begin
      state_d    = HOLD;
      code_q_d   = bus.y;
      v_n_d      = line_n(bus.y);
      busy_d     = 1'b1;
      hold_cnt_d = HOLD_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.scan_en) begin
            state_d    = SCAN;
            scan_idx_d = 3'd0;
            v_n_d      = 8'hFE;
            div_cnt_d  = SCAN_LOAD;
          end else begin
            v_n_d = 8'hFF;
          end
        end
        HOLD: begin
          if (hold_cnt_q == '0) begin
            state_d = IDLE;
            v_n_d   = 8'hFF;
            busy_d  = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        SCAN: begin
          if (!bus.scan_en) begin
            state_d = IDLE;
            v_n_d   = 8'hFF;
          end else if (div_cnt_q == '0) begin
            scan_idx_d = scan_next;
            v_n_d      = line_n(scan_next);
            div_cnt_d  = SCAN_LOAD;
          end else begin
            div_cnt_d = div_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          v_n_d   = 8'hFF;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      v_n_q      <= 8'hFF;
      busy_q     <= 1'b0;
      code_q_q   <= 3'd0;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      scan_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      v_n_q      <= v_n_d;
      busy_q     <= busy_d;
      code_q_q   <= code_q_d;
      hold_cnt_q <= hold_cnt_d;
      div_cnt_q  <= div_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign bus.v_n    = v_n_q;
  assign bus.busy   = busy_q;
  assign bus.code_q = code_q_q;

endmodule

// File: tb/tb__3_to_8_hold_decoder.sv
// Directed-vector bench for the hold decoder with HOLD_CYCLES=4 and SCAN_DIV=2.
module tb__3_to_8_hold_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vectors     = 0;
  int   n_miscompares = 0;

  _3_to_8_hold_decoder_if bus ();

  _3_to_8_hold_decoder #(.HOLD_CYCLES(4), .SCAN_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en_n, input logic gs_v, input logic [2:0] y_v);
    bus.en_in_n = en_n;
    bus.gs      = gs_v;
    bus.y       = y_v;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] v, input logic b, input logic [2:0] c);
    check({tag, ".v_n"},    32'(bus.v_n),    32'(v));
    check({tag, ".busy"},   32'(bus.busy),   32'(b));
    check({tag, ".code_q"}, 32'(bus.code_q), 32'(c));
  endtask

  initial begin
    bus.scan_en = 1'b0;
    set_in(1'b1, 1'b1, 3'd0);

    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    expect_out("reset", 8'hFF, 1'b0, 3'd0);

    // Single-cycle capture of y=3: four cycles of F7 then release
    set_in(1'b0, 1'b0, 3'd3);
    cycle();
    set_in(1'b1, 1'b1, 3'd0);
    expect_out("hold3_c1", 8'hF7, 1'b1, 3'd3);
    for (int i = 2; i <= 4; i++) begin
      cycle();
      expect_out($sformatf("hold3_c%0d", i), 8'hF7, 1'b1, 3'd3);
    end
    cycle();
    expect_out("hold3_end", 8'hFF, 1'b0, 3'd3);

    // Retrigger: y=1, then y=6 two cycles later, no all-high gap
    set_in(1'b0, 1'b0, 3'd1);
    cycle();
    set_in(1'b1, 1'b1, 3'd0);
    expect_out("retrig_a1", 8'hFD, 1'b1, 3'd1);
    cycle();
    expect_out("retrig_a2", 8'hFD, 1'b1, 3'd1);
    set_in(1'b0, 1'b0, 3'd6);
    cycle();
    set_in(1'b1, 1'b1, 3'd0);
    expect_out("retrig_b1", 8'hBF, 1'b1, 3'd6);
    for (int i = 2; i <= 4; i++) begin
      cycle();
      expect_out($sformatf("retrig_b%0d", i), 8'hBF, 1'b1, 3'd6);
    end
    cycle();
    expect_out("retrig_end", 8'hFF, 1'b0, 3'd6);

    // Gating: either strobe inactive means no capture
    set_in(1'b1, 1'b0, 3'd2);
    cycle();
    expect_out("gate_en_off", 8'hFF, 1'b0, 3'd6);
    set_in(1'b0, 1'b1, 3'd2);
    cycle();
    expect_out("gate_gs_off", 8'hFF, 1'b0, 3'd6);
    set_in(1'b1, 1'b1, 3'd0);

    // Scan walk with wrap: each position held for 2 cycles
    bus.scan_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cycle();
      check($sformatf("scan_k%0d", k), 32'(bus.v_n), 32'(8'(~(8'd1 << ((k / 2) % 8)))));
    end
    check("scan_busy", 32'(bus.busy), 32'd0);
    bus.scan_en = 1'b0;
    cycle();
    expect_out("scan_drop", 8'hFF, 1'b0, 3'd6);

    // Restart scan, capture y=0 at position 5
    bus.scan_en = 1'b1;
    cycle();
    check("rescan_start", 32'(bus.v_n), 32'h0000_00FE);
    for (int k = 1; k <= 10; k++) cycle();
    check("rescan_pos5", 32'(bus.v_n), 32'h0000_00DF);
    set_in(1'b0, 1'b0, 3'd0);
    cycle();
    set_in(1'b1, 1'b1, 3'd0);
    expect_out("scan_cap_c1", 8'hFE, 1'b1, 3'd0);
    for (int i = 2; i <= 4; i++) begin
      cycle();
      expect_out($sformatf("scan_cap_c%0d", i), 8'hFE, 1'b1, 3'd0);
    end
    cycle();
    expect_out("scan_cap_idle", 8'hFF, 1'b0, 3'd0);
    cycle();
    expect_out("scan_cap_rescan", 8'hFE, 1'b0, 3'd0);

    // Continuous capture follows y every cycle
    set_in(1'b0, 1'b0, 3'd2);
    cycle();
    expect_out("follow_y2", 8'hFB, 1'b1, 3'd2);
    bus.y = 3'd5;
    cycle();
    expect_out("follow_y5", 8'hDF, 1'b1, 3'd5);
    bus.y = 3'd4;
    for (int i = 0; i < 6; i++) cycle();
    expect_out("follow_long", 8'hEF, 1'b1, 3'd4);
    set_in(1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) cycle();
    expect_out("follow_end", 8'hFF, 1'b0, 3'd4);

    // Sync reset mid-hold; a pulse between edges is ignored
    bus.scan_en = 1'b0;
    set_in(1'b0, 1'b0, 3'd7);
    cycle();
    set_in(1'b1, 1'b1, 3'd0);
    expect_out("rst_hold_c1", 8'h7F, 1'b1, 3'd7);
    cycle();
    expect_out("rst_hold_c2", 8'h7F, 1'b1, 3'd7);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cycle();
    expect_out("rst_async_ignored", 8'h7F, 1'b1, 3'd7);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    expect_out("rst_sync", 8'hFF, 1'b0, 3'd0);
    cycle();
    expect_out("rst_after", 8'hFF, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
